// File: rtl/ratio_div_sched_if.sv
// ratio_div_sched_if
// Signal bundle between the ratio scheduler, its two requesting channels,
// the shared pipelined divider and the ratio RAM.
//
// Handshake: a channel raises x_req with x_numer/x_addr stable and holds all
// three until it sees the one-cycle x_ack. A request still high in the cycle
// after its ack counts as a new request.
//
// Signals:
//   a_req/a_numer/a_addr/a_ack  channel A (signal) request and done pulse
//   b_req/b_numer/b_addr/b_ack  channel B (reference) request and done pulse
//   div_clken/div_numer/div_denom/div_quot  shared divider
//   mem_wren/mem_addr/mem_data  ratio RAM write port
//
// Modports:
//   master  scheduler side (drives acks, divider inputs, RAM write)
//   slave   environment side (channels, divider, RAM)
interface ratio_div_sched_if #(
    parameter int NW = 16,
    parameter int QW = 12,
    parameter int AW = 11
);
    logic          a_req;
    logic [NW-1:0] a_numer;
    logic [AW-1:0] a_addr;
    logic          a_ack;

    logic          b_req;
    logic [NW-1:0] b_numer;
    logic [AW-1:0] b_addr;
    logic          b_ack;

    logic          div_clken;
    logic [NW-1:0] div_numer;
    logic [3:0]    div_denom;
    logic [NW-1:0] div_quot;

    logic          mem_wren;
    logic [AW:0]   mem_addr;
    logic [QW-1:0] mem_data;

    modport master (
        input  a_req, a_numer, a_addr,
        input  b_req, b_numer, b_addr,
        input  div_quot,
        output a_ack, b_ack,
        output div_clken, div_numer, div_denom,
        output mem_wren, mem_addr, mem_data
    );

    modport slave (
        output a_req, a_numer, a_addr,
        output b_req, b_numer, b_addr,
        output div_quot,
        input  a_ack, b_ack,
        input  div_clken, div_numer, div_denom,
        input  mem_wren, mem_addr, mem_data
    );
endinterface

// File: rtl/ratio_div_sched.sv
// ratio_div_sched
// Shares one pipelined NW/4-bit divider between channel A (signal) and
// channel B (reference). One request is granted at a time: the numerator is
// issued to the divider, the scheduler waits out the divider latency, writes
// the saturated quotient to the ratio RAM and acks the requester. Completed
// writes are counted per frame; frame_done pulses on the write that brings
// the count to 2*points.
//
// Optional build macro RATIO_ROUND_EN: when defined, DENOM/2 is added to the
// numerator (saturating) so quotients round half-up; otherwise they truncate.
// Timing and handshake are the same in both builds.
//
// Ports:
//   clk, rst_n    clock, synchronous active-low reset
//   enable        frame enable; low blocks new grants and clears cnt_done
//   points        points per channel per frame (0 = frame never completes)
//   bus           ratio_div_sched_if.master: channels, divider, RAM
//   busy          high whenever the FSM is not idle
//   frame_done    one-cycle pulse on the last write of a frame
//   cnt_done      writes completed in the current frame
//   state_dbg     current FSM state encoding (0 idle,1 issue,2 wait,3 write)
module ratio_div_sched #(
    parameter int NW      = 16,
    parameter int QW      = 12,
    parameter int AW      = 11,
    parameter int DIV_LAT = 3,
    parameter int DENOM   = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [AW-1:0]          points,
    ratio_div_sched_if.master      bus,
    output logic                   busy,
    output logic                   frame_done,
    output logic [AW:0]            cnt_done,
    output logic [1:0]             state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    // Latency counter only needs to reach DIV_LAT-1.
    localparam int LW = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
    localparam logic [LW-1:0] LAT_LAST = LW'(DIV_LAT - 1);

    localparam logic CH_A = 1'b0;
    localparam logic CH_B = 1'b1;

    state_t          state_q;
    state_t          state_d;
    logic [LW-1:0]   lat_cnt_q;
    logic            last_grant_q;
    logic            gnt_ch_q;
    logic [AW-1:0]   gnt_addr_q;
    logic [NW-1:0]   div_numer_q;
    logic [AW:0]     cnt_done_q;

    logic            grant_valid;
    logic            grant_ch;
    logic [NW-1:0]   sel_numer;
    logic [NW-1:0]   issue_numer;
    logic [QW-1:0]   quot_sat;
    logic            frame_hit;

    // ------------------------------------------------------------------
    // Next-state and grant decision
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_valid = 1'b0;
        grant_ch    = CH_A;
        case (state_q)
            S_IDLE: begin
                if (enable && (bus.a_req || bus.b_req)) begin
                    grant_valid = 1'b1;
                    // On a tie the channel that did not win last time goes;
                    // otherwise whichever channel is asking.
                    if (bus.a_req && bus.b_req) begin
                        grant_ch = ~last_grant_q;
                    end else begin
                        grant_ch = bus.b_req;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (lat_cnt_q == LAT_LAST) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Numerator presented to the divider
    // ------------------------------------------------------------------
    assign sel_numer = grant_ch ? bus.b_numer : bus.a_numer;

`ifdef RATIO_ROUND_EN
    logic [NW:0] round_sum;
    // Half the denominator biases the truncating divider to round half-up;
    // the carry-out saturates so large sums never wrap to small quotients.
    assign round_sum   = {1'b0, sel_numer} + (NW+1)'(DENOM / 2);
    assign issue_numer = round_sum[NW] ? {NW{1'b1}} : round_sum[NW-1:0];
`else
    assign issue_numer = sel_numer;
`endif

    // Quotients that overflow the RAM word are clamped to all-ones.
    assign quot_sat = (|bus.div_quot[NW-1:QW]) ? {QW{1'b1}}
                                               : bus.div_quot[QW-1:0];

    // Points == 0 disables frame completion; cnt_done then wraps freely.
    assign frame_hit = (points != '0) &&
                       ((cnt_done_q + (AW+1)'(1)) == {points, 1'b0});

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lat_cnt_q    <= '0;
            last_grant_q <= CH_B;
            gnt_ch_q     <= CH_A;
            gnt_addr_q   <= '0;
            div_numer_q  <= '0;
            cnt_done_q   <= '0;
        end else begin
            state_q <= state_d;

            if (grant_valid) begin
                gnt_ch_q     <= grant_ch;
                gnt_addr_q   <= grant_ch ? bus.b_addr : bus.a_addr;
                div_numer_q  <= issue_numer;
                last_grant_q <= grant_ch;
            end

            case (state_q)
                S_ISSUE: lat_cnt_q <= '0;
                S_WAIT:  lat_cnt_q <= lat_cnt_q + LW'(1);
                default: lat_cnt_q <= lat_cnt_q;
            endcase

            if (state_q == S_WRITE) begin
                cnt_done_q <= frame_hit ? '0 : cnt_done_q + (AW+1)'(1);
            end else if (state_q == S_IDLE && !enable) begin
                cnt_done_q <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.div_clken = (state_q == S_ISSUE) || (state_q == S_WAIT);
        bus.div_numer = div_numer_q;
        bus.div_denom = 4'(DENOM);
        bus.mem_wren  = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_data  = '0;
        bus.a_ack     = 1'b0;
        bus.b_ack     = 1'b0;
        frame_done    = 1'b0;
        if (state_q == S_WRITE) begin
            bus.mem_wren = 1'b1;
            bus.mem_addr = {gnt_ch_q, gnt_addr_q};
            bus.mem_data = quot_sat;
            bus.a_ack    = (gnt_ch_q == CH_A);
            bus.b_ack    = (gnt_ch_q == CH_B);
            frame_done   = frame_hit;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign cnt_done  = cnt_done_q;
    assign state_dbg = state_q;

endmodule

// File: doc/ratio_div_sched.md
Name: ratio_div_sched

Overview:
Scheduler that shares one pipelined 16/4-bit divider between two channels (A = signal, B = reference) that produce ten-sample sums per spectral point. It grants the divider to one requester at a time, issues the division, waits the fixed pipeline latency, writes the quotient to the ratio RAM, and acks the requester. It counts completed writes per frame and flags frame completion. It sits between the per-point accumulators and the ratio RAM/divider.

Parameters:
NW, 16, numerator width
QW, 12, quotient width written to RAM
AW, 11, point address width
DIV_LAT, 3, divider pipeline latency in clken-high cycles
DENOM, 10, constant denominator driven to the divider

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
enable  in  1  frame enable; low = no new grants
points  in  AW  points per channel per frame
a_req  in  1  channel A request; held until a_ack
a_numer  in  NW  channel A sum; stable while a_req
a_addr  in  AW  channel A point index
a_ack  out  1  one-cycle done pulse to A
b_req / b_numer / b_addr / b_ack  same as A, for channel B
div_clken  out  1  divider clock enable
div_numer  out  NW  divider numerator
div_denom  out  4  divider denominator, constant DENOM
div_quot  in  NW  divider quotient
mem_wren  out  1  RAM write strobe
mem_addr  out  AW+1  {channel bit (A=0,B=1), point index}
mem_data  out  QW  div_quot[QW-1:0], saturated to all-ones if upper bits non-zero
busy  out  1  high in any state other than IDLE
frame_done  out  1  one-cycle pulse at end of frame
cnt_done  out  AW+1  writes completed in current frame

Behaviour:
- Reset (rst_n low at posedge): state IDLE. All outputs 0, except div_denom = DENOM. last_grant = B, so A wins the first tie. Any in-flight op is aborted with no write and no ack.
- FSM:
  - IDLE: if enable and any req, grant, latch numer/addr/channel, go to ISSUE. Only one req active: grant it. Both active: grant the channel != last_grant; update last_grant.
  - ISSUE: 1 cycle. div_numer = latched value, div_clken = 1, latency counter = 0. Go to WAIT.
  - WAIT: div_clken = 1, counter increments each cycle. Go to WRITE when counter == DIV_LAT-1.
  - WRITE: 1 cycle. mem_wren = 1, mem_addr/mem_data valid, granted ack = 1, cnt_done += 1. Go to IDLE.
- Latency: first cycle req is sampled in IDLE to ack = DIV_LAT+2 cycles. Back-to-back throughput is one op per DIV_LAT+3 cycles.
- A req still high in the cycle after its ack is treated as a new request.
- div_numer holds its last value outside ISSUE/WAIT. div_clken is 0 outside ISSUE/WAIT.
- Frame: in WRITE, if cnt_done+1 == 2*points, pulse frame_done in the same cycle and clear cnt_done to 0 instead of incrementing. With points == 0, frame_done never fires and cnt_done wraps modulo 2^(AW+1).
- enable falling mid-op: the current op completes, including write and ack. No further grants. cnt_done clears in IDLE while enable is low.
- Simultaneous frame_done and new req: the req is serviced normally on the next IDLE.

Optional Feature:
RATIO_ROUND_EN:
- Defined: div_numer = latched numer + DENOM/2, saturating at 2^NW-1, so quotients round half-up.
- Undefined: div_numer = latched numer, so quotients truncate.
- Timing and handshake are identical in both builds.

Test Plan:
- Single A req, a_numer=1234, a_addr=5 -> a_ack exactly 5 cycles after req is sampled (DIV_LAT=3). mem_addr=0x005, mem_data=123 in both builds.
- a_numer=1235 -> mem_data=123 without RATIO_ROUND_EN, 124 with it. a_numer=65535 with rounding -> div_numer saturates at 65535, mem_data=4095 (6553 saturated).
- a_req and b_req asserted together from reset, held 4 ops -> grant order A,B,A,B. B writes at mem_addr bit 11 = 1.
- points=3, 6 alternating ops -> cnt_done steps 1..5, then frame_done pulses on the 6th WRITE and cnt_done returns to 0.
- rst_n low during WAIT -> no mem_wren, no ack, busy=0 next cycle. Held req is re-serviced fully after reset release.
- enable dropped during WAIT -> current write and ack occur. Pending b_req is not granted until enable returns. cnt_done = 0 while idle with enable low.
